// File: rtl/riscv_pkg.sv
// Shared RV32M/RV64M definitions: funct3 encodings, muldiv FSM states and
// operand-signedness helpers used by the iterative multiply/divide unit.
package riscv_pkg;

    localparam logic [2:0] F3_MUL    = 3'd0;
    localparam logic [2:0] F3_MULH   = 3'd1;
    localparam logic [2:0] F3_MULHSU = 3'd2;
    localparam logic [2:0] F3_MULHU  = 3'd3;
    localparam logic [2:0] F3_DIV    = 3'd4;
    localparam logic [2:0] F3_DIVU   = 3'd5;
    localparam logic [2:0] F3_REM    = 3'd6;
    localparam logic [2:0] F3_REMU   = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } muldiv_state_e;

    function automatic logic is_signed_rs1(input logic [2:0] op);
        return (op == F3_MULH) || (op == F3_MULHSU) || (op == F3_DIV) || (op == F3_REM);
    endfunction

    function automatic logic is_signed_rs2(input logic [2:0] op);
        return (op == F3_MULH) || (op == F3_DIV) || (op == F3_REM);
    endfunction

    function automatic logic is_div(input logic [2:0] op);
        return op[2];
    endfunction

endpackage

// File: rtl/restoring_div_step.sv
// One restoring-division step on unsigned magnitudes: shift the next dividend
// bit into the partial remainder and keep the trial subtraction if it fits.
module restoring_div_step #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] i_rem,
    input  logic [XLEN-1:0] i_quo,
    input  logic [XLEN-1:0] i_divisor,
    output logic [XLEN-1:0] o_rem,
    output logic [XLEN-1:0] o_quo
);

    logic [XLEN:0] w_shift;
    logic [XLEN:0] w_diff;

    // Remainder stays below the divisor, so the shifted value fits XLEN+1 bits.
    assign w_shift = {i_rem, i_quo[XLEN-1]};
    assign w_diff  = w_shift - {1'b0, i_divisor};

    always_comb begin
        o_rem = w_shift[XLEN-1:0];
        o_quo = {i_quo[XLEN-2:0], 1'b0};
        if (!w_diff[XLEN]) begin
            o_rem = w_diff[XLEN-1:0];
            o_quo = {i_quo[XLEN-2:0], 1'b1};
        end
    end

endmodule

// File: rtl/muldiv_iter_unit.sv
// Iterative RV M-extension multiply/divide unit with valid/ready in and out.
// Define MULDIV_EARLY_OUT_EN to finish zero-operand multiplies and |rs1|<|rs2| divides in one cycle.
module muldiv_iter_unit #(
    parameter int XLEN     = 32,
    parameter int MUL_STEP = 1,
    parameter int TAG_W    = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [2:0]       op,
    input  logic [XLEN-1:0]  rs1,
    input  logic [XLEN-1:0]  rs2,
    input  logic [TAG_W-1:0] tag_in,
    input  logic             flush,
    output logic             busy,
    output logic             result_valid,
    input  logic             result_ready,
    output logic [XLEN-1:0]  result,
    output logic [TAG_W-1:0] tag_out
);
    import riscv_pkg::*;

    localparam int MUL_CYC = XLEN / MUL_STEP;
    localparam int CNT_W   = $clog2(XLEN + 1);
    localparam logic [CNT_W-1:0] MUL_CNT0 = CNT_W'(MUL_CYC - 1);
    localparam logic [CNT_W-1:0] DIV_CNT0 = CNT_W'(XLEN - 1);
    localparam logic [XLEN-1:0]  MIN_INT  = {1'b1, {(XLEN-1){1'b0}}};

    muldiv_state_e r_state, w_state_next;

    logic [2:0]        r_op;
    logic [TAG_W-1:0]  r_tag;
    logic              r_neg;
    logic              r_rneg;
    logic [CNT_W-1:0]  r_count;
    logic [2*XLEN-1:0] r_acc;
    logic [XLEN-1:0]   r_a;
    logic [XLEN-1:0]   r_b;
    logic [XLEN-1:0]   r_rem;
    logic [XLEN-1:0]   r_quo;
    logic [XLEN-1:0]   r_dvs;
    logic [XLEN-1:0]   r_result;
    logic [TAG_W-1:0]  r_tag_out;

    logic            w_idle, w_accept, w_sign1, w_sign2, w_is_div;
    logic            w_div_zero, w_ovf, w_early, w_special;
    logic [XLEN-1:0] w_mag1, w_mag2, w_special_res;

    assign w_idle   = (r_state == ST_IDLE);
    assign w_accept = start_valid && start_ready;
    assign w_sign1  = is_signed_rs1(op) & rs1[XLEN-1];
    assign w_sign2  = is_signed_rs2(op) & rs2[XLEN-1];
    assign w_is_div = is_div(op);
    // MIN_INT negates to itself, which is already the right unsigned magnitude.
    assign w_mag1   = w_sign1 ? -rs1 : rs1;
    assign w_mag2   = w_sign2 ? -rs2 : rs2;

    assign w_div_zero = w_is_div && (rs2 == '0);
    assign w_ovf      = ((op == F3_DIV) || (op == F3_REM)) && (rs1 == MIN_INT) && (rs2 == {XLEN{1'b1}});
`ifdef MULDIV_EARLY_OUT_EN
    assign w_early    = w_is_div ? (w_mag1 < w_mag2) : ((rs1 == '0) || (rs2 == '0));
`else
    assign w_early    = 1'b0;
`endif
    assign w_special  = w_div_zero || w_ovf || w_early;

    always_comb begin
        w_special_res = '0;
        if (w_div_zero)
            w_special_res = op[1] ? rs1 : {XLEN{1'b1}};
        else if (w_ovf)
            w_special_res = op[1] ? '0 : MIN_INT;
        else if (w_is_div)
            w_special_res = op[1] ? rs1 : '0;
    end

    // The accepting edge already retires the first iteration from the live operands.
    logic [2*XLEN-1:0] w_in_acc, w_acc_nx, w_pp_sum;
    logic [XLEN-1:0]   w_in_a, w_in_b, w_b_nx;
    logic [XLEN-1:0]   w_in_rem, w_in_quo, w_in_dvs, w_rem_nx, w_quo_nx;
    logic [MUL_STEP-1:0] w_digit;
    logic [2*XLEN-1:0] w_pp [MUL_STEP];

    assign w_in_acc = w_idle ? '0     : r_acc;
    assign w_in_a   = w_idle ? w_mag1 : r_a;
    assign w_in_b   = w_idle ? w_mag2 : r_b;
    assign w_in_rem = w_idle ? '0     : r_rem;
    assign w_in_quo = w_idle ? w_mag1 : r_quo;
    assign w_in_dvs = w_idle ? w_mag2 : r_dvs;

    assign w_digit = w_in_b[XLEN-1 -: MUL_STEP];
    assign w_b_nx  = w_in_b << MUL_STEP;

    genvar gi;
    generate
        for (gi = 0; gi < MUL_STEP; gi++) begin : g_pp
            assign w_pp[gi] = w_digit[gi] ? ({{XLEN{1'b0}}, w_in_a} << gi) : '0;
        end
    endgenerate

    always_comb begin
        w_pp_sum = '0;
        for (int k = 0; k < MUL_STEP; k++)
            w_pp_sum = w_pp_sum + w_pp[k];
    end

    assign w_acc_nx = (w_in_acc << MUL_STEP) + w_pp_sum;

    restoring_div_step #(.XLEN(XLEN)) u_div_step (
        .i_rem     (w_in_rem),
        .i_quo     (w_in_quo),
        .i_divisor (w_in_dvs),
        .o_rem     (w_rem_nx),
        .o_quo     (w_quo_nx)
    );

    logic [2*XLEN-1:0] w_mul_full;
    logic [XLEN-1:0]   w_mul_res, w_quo_fin, w_rem_fin, w_div_res;

    assign w_mul_full = r_neg ? -w_acc_nx : w_acc_nx;
    assign w_mul_res  = (r_op == F3_MUL) ? w_mul_full[XLEN-1:0] : w_mul_full[2*XLEN-1:XLEN];
    assign w_quo_fin  = r_neg  ? -w_quo_nx : w_quo_nx;
    assign w_rem_fin  = r_rneg ? -w_rem_nx : w_rem_nx;
    assign w_div_res  = r_op[1] ? w_rem_fin : w_quo_fin;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        start_ready  = w_idle && !flush;
        busy         = !w_idle;
        result_valid = (r_state == ST_DONE);
        case (r_state)
            ST_IDLE: begin
                if (w_accept)
                    w_state_next = w_special ? ST_DONE : (w_is_div ? ST_DIV : ST_MUL);
            end
            ST_MUL, ST_DIV: begin
                if (r_count == CNT_W'(1))
                    w_state_next = ST_DONE;
            end
            ST_DONE: begin
                if (result_ready)
                    w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
        if (flush)
            w_state_next = ST_IDLE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_op      <= '0;
            r_tag     <= '0;
            r_neg     <= 1'b0;
            r_rneg    <= 1'b0;
            r_count   <= '0;
            r_acc     <= '0;
            r_a       <= '0;
            r_b       <= '0;
            r_rem     <= '0;
            r_quo     <= '0;
            r_dvs     <= '0;
            r_result  <= '0;
            r_tag_out <= '0;
        end else if (!flush) begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_op    <= op;
                        r_tag   <= tag_in;
                        r_neg   <= w_sign1 ^ w_sign2;
                        r_rneg  <= w_sign1;
                        r_count <= w_is_div ? DIV_CNT0 : MUL_CNT0;
                        r_acc   <= w_acc_nx;
                        r_a     <= w_mag1;
                        r_b     <= w_b_nx;
                        r_rem   <= w_rem_nx;
                        r_quo   <= w_quo_nx;
                        r_dvs   <= w_mag2;
                        if (w_special) begin
                            r_result  <= w_special_res;
                            r_tag_out <= tag_in;
                        end
                    end
                end
                ST_MUL: begin
                    r_acc   <= w_acc_nx;
                    r_b     <= w_b_nx;
                    r_count <= r_count - 1'b1;
                    if (r_count == CNT_W'(1)) begin
                        r_result  <= w_mul_res;
                        r_tag_out <= r_tag;
                    end
                end
                ST_DIV: begin
                    r_rem   <= w_rem_nx;
                    r_quo   <= w_quo_nx;
                    r_count <= r_count - 1'b1;
                    if (r_count == CNT_W'(1)) begin
                        r_result  <= w_div_res;
                        r_tag_out <= r_tag;
                    end
                end
                default: ;
            endcase
        end
    end

    assign result  = r_result;
    assign tag_out = r_tag_out;

endmodule

// File: tb/tb_muldiv_iter_unit.sv
// Directed bench for muldiv_iter_unit: a MUL_STEP=1 instance and a MUL_STEP=4 instance.
module tb_muldiv_iter_unit;
    import riscv_pkg::*;

`ifdef MULDIV_EARLY_OUT_EN
    localparam int EO_LAT = 1;
`else
    localparam int EO_LAT = 32;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        flush = 1'b0;
    logic        start_valid1 = 1'b0, start_valid4 = 1'b0;
    logic        result_ready1 = 1'b0, result_ready4 = 1'b0;
    logic [2:0]  op = '0;
    logic [31:0] rs1 = '0, rs2 = '0;
    logic [4:0]  tag_in = '0;

    logic        start_ready1, busy1, result_valid1;
    logic        start_ready4, busy4, result_valid4;
    logic [31:0] result1, result4;
    logic [4:0]  tag_out1, tag_out4;

    int n_cmp = 0;
    int n_fail = 0;
    int cur = 1;

    logic        cur_ready, cur_busy, cur_valid;
    logic [31:0] cur_result;
    logic [4:0]  cur_tag;
    assign cur_ready  = (cur == 4) ? start_ready4  : start_ready1;
    assign cur_busy   = (cur == 4) ? busy4         : busy1;
    assign cur_valid  = (cur == 4) ? result_valid4 : result_valid1;
    assign cur_result = (cur == 4) ? result4       : result1;
    assign cur_tag    = (cur == 4) ? tag_out4      : tag_out1;

    always #5 clk = ~clk;

    muldiv_iter_unit #(.XLEN(32), .MUL_STEP(1), .TAG_W(5)) u_dut1 (
        .clk(clk), .reset(reset), .start_valid(start_valid1), .start_ready(start_ready1),
        .op(op), .rs1(rs1), .rs2(rs2), .tag_in(tag_in), .flush(flush), .busy(busy1),
        .result_valid(result_valid1), .result_ready(result_ready1), .result(result1), .tag_out(tag_out1)
    );

    muldiv_iter_unit #(.XLEN(32), .MUL_STEP(4), .TAG_W(5)) u_dut4 (
        .clk(clk), .reset(reset), .start_valid(start_valid4), .start_ready(start_ready4),
        .op(op), .rs1(rs1), .rs2(rs2), .tag_in(tag_in), .flush(flush), .busy(busy4),
        .result_valid(result_valid4), .result_ready(result_ready4), .result(result4), .tag_out(tag_out4)
    );

    task automatic check(input string name, input logic [63:0] observed, input logic [63:0] expected);
        n_cmp++;
        assert (observed === expected) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", name, observed, expected);
        end
    endtask

    // Offer one op, measure latency (first negedge after the accept edge = 1), then consume it.
    task automatic run_op(input int sel, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] t, input logic [31:0] exp_res, input int exp_lat, input string name);
        int   lat;
        logic got;
        logic busy_ok;
        cur = sel;
        @(negedge clk);
        op = o; rs1 = a; rs2 = b; tag_in = t;
        if (sel == 4) start_valid4 = 1'b1; else start_valid1 = 1'b1;
        #1 check({name, ".start_ready"}, cur_ready, 1);
        @(posedge clk);
        #1;
        start_valid1 = 1'b0; start_valid4 = 1'b0;
        op = ~o; rs1 = ~a; rs2 = ~b; tag_in = ~t;
        lat = 0; got = 1'b0; busy_ok = 1'b1;
        while (!got && lat < 100) begin
            @(negedge clk);
            lat++;
            busy_ok = busy_ok & cur_busy;
            got = cur_valid;
        end
        check({name, ".latency"}, lat, exp_lat);
        check({name, ".busy"}, busy_ok, 1);
        check({name, ".result"}, cur_result, exp_res);
        check({name, ".tag"}, cur_tag, t);
        $display("txn %s dut=x%0d op=%0d rs1=%h rs2=%h result=%h tag=%0d lat=%0d",
                 name, sel, o, a, b, cur_result, cur_tag, lat);
        if (sel == 4) result_ready4 = 1'b1; else result_ready1 = 1'b1;
        @(posedge clk);
        #1;
        result_ready1 = 1'b0; result_ready4 = 1'b0;
        @(negedge clk);
        check({name, ".valid_drop"}, cur_valid, 0);
        check({name, ".start_ready_after"}, cur_ready, 1);
    endtask

    initial begin
        logic ok;
        logic seen;

        repeat (2) @(negedge clk);
        check("reset.busy", busy1, 0);
        check("reset.result_valid", result_valid1, 0);
        check("reset.result", result1, 0);
        check("reset.tag_out", tag_out1, 0);
        reset = 1'b0;

        run_op(1, F3_MUL,    32'd7,        32'hFFFFFFFD, 5'd5, 32'hFFFFFFEB, 32, "mul_7xm3");
        run_op(1, F3_MULH,   32'h80000000, 32'h80000000, 5'd1, 32'h40000000, 32, "mulh_min");
        run_op(1, F3_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 5'd2, 32'hFFFFFFFE, 32, "mulhu_ones");
        run_op(1, F3_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd3, 32'hFFFFFFFF, 32, "mulhsu_ones");
        run_op(4, F3_MULH,   32'h80000000, 32'h80000000, 5'd1, 32'h40000000, 8,  "s4_mulh_min");
        run_op(4, F3_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 5'd2, 32'hFFFFFFFE, 8,  "s4_mulhu_ones");
        run_op(4, F3_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd3, 32'hFFFFFFFF, 8,  "s4_mulhsu_ones");
        run_op(4, F3_MUL,    32'd7,        32'hFFFFFFFD, 5'd4, 32'hFFFFFFEB, 8,  "s4_mul_7xm3");

        run_op(1, F3_DIV,  32'hFFFFFFF9, 32'd2, 5'd6,  32'hFFFFFFFD, 32, "div_m7_2");
        run_op(1, F3_REM,  32'hFFFFFFF9, 32'd2, 5'd7,  32'hFFFFFFFF, 32, "rem_m7_2");
        run_op(1, F3_DIVU, 32'd100,      32'd7, 5'd8,  32'd14,       32, "divu_100_7");
        run_op(1, F3_REMU, 32'd100,      32'd7, 5'd9,  32'd2,        32, "remu_100_7");
        run_op(1, F3_DIV,  32'h80000000, 32'd2, 5'd10, 32'hC0000000, 32, "div_min_2");

        run_op(1, F3_DIV,  32'd5,        32'd0,        5'd11, 32'hFFFFFFFF, 1, "div_by0");
        run_op(1, F3_REM,  32'd5,        32'd0,        5'd12, 32'd5,        1, "rem_by0");
        run_op(1, F3_REMU, 32'hFFFFFFF9, 32'd0,        5'd13, 32'hFFFFFFF9, 1, "remu_by0");
        run_op(1, F3_DIV,  32'h80000000, 32'hFFFFFFFF, 5'd14, 32'h80000000, 1, "div_ovf");
        run_op(1, F3_REM,  32'h80000000, 32'hFFFFFFFF, 5'd15, 32'd0,        1, "rem_ovf");

        // Backpressure: result must hold for five cycles with result_ready low.
        cur = 1;
        @(negedge clk);
        op = F3_DIV; rs1 = 32'd5; rs2 = 32'd0; tag_in = 5'd9; start_valid1 = 1'b1;
        @(posedge clk);
        #1 start_valid1 = 1'b0;
        ok = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            ok = ok & (result_valid1 === 1'b1) & (result1 === 32'hFFFFFFFF) & (tag_out1 === 5'd9) & (start_ready1 === 1'b0);
        end
        check("bp.stable", ok, 1);
        result_ready1 = 1'b1;
        @(posedge clk);
        #1 result_ready1 = 1'b0;
        @(negedge clk);
        check("bp.valid_drop", result_valid1, 0);
        check("bp.start_ready", start_ready1, 1);
        $display("txn backpressure result=%h tag=%0d", result1, tag_out1);

        // Reset mid-multiply, between clock edges.
        @(negedge clk);
        op = F3_MUL; rs1 = 32'd3; rs2 = 32'd5; tag_in = 5'd7; start_valid1 = 1'b1;
        @(posedge clk);
        #1 start_valid1 = 1'b0;
        repeat (7) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("areset.busy", busy1, 0);
        check("areset.result_valid", result_valid1, 0);
        check("areset.result", result1, 0);
        check("areset.tag_out", tag_out1, 0);
        $display("txn async_reset busy=%0d result=%h", busy1, result1);
        @(negedge clk);
        reset = 1'b0;

        // Flush at cycle 10 of a divide.
        @(negedge clk);
        op = F3_DIV; rs1 = 32'hFFFFFFF9; rs2 = 32'd2; tag_in = 5'd3; start_valid1 = 1'b1;
        @(posedge clk);
        #1 start_valid1 = 1'b0;
        seen = 1'b0;
        repeat (10) begin
            @(negedge clk);
            seen = seen | result_valid1;
        end
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        @(negedge clk);
        check("flush.busy", busy1, 0);
        check("flush.start_ready", start_ready1, 1);
        repeat (40) begin
            @(negedge clk);
            seen = seen | result_valid1;
        end
        check("flush.no_result", seen, 0);
        $display("txn flush_div seen_valid=%0d", seen);

        // A start offered while flush is high must not be taken.
        @(negedge clk);
        flush = 1'b1; op = F3_MUL; rs1 = 32'd2; rs2 = 32'd3; start_valid1 = 1'b1;
        #1 check("flush.start_blocked", start_ready1, 0);
        @(posedge clk);
        #1 begin flush = 1'b0; start_valid1 = 1'b0; end
        @(negedge clk);
        check("flush.not_accepted", busy1, 0);
        $display("txn flush_start busy=%0d", busy1);

        run_op(1, F3_MUL,  32'd0,        32'h1234, 5'd20, 32'd0,        EO_LAT, "eo_mul_zero");
        run_op(1, F3_DIVU, 32'd3,        32'd9,    5'd21, 32'd0,        EO_LAT, "eo_divu_3_9");
        run_op(1, F3_REM,  32'hFFFFFFFD, 32'd9,    5'd22, 32'hFFFFFFFD, EO_LAT, "eo_rem_m3_9");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish expected finish before 200000 ns");
        $fatal(1, "watchdog expired");
    end

endmodule
